// File: rtl/dpe_vec_loader.sv
// Serial-to-vector packer feeding the DPE column adder: a fill buffer plus an output register
// sustain one element per cycle. Optional partial-vector flush under `DPE_LOADER_FLUSH_EN.
module dpe_vec_loader #(
  parameter int INPUT_VEC_LEN = 8,
  parameter int WIDTH         = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WIDTH-1:0]                      in_data,
`ifdef DPE_LOADER_FLUSH_EN
  input  logic                                  flush,
`endif
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [INPUT_VEC_LEN-1:0][WIDTH-1:0]   out_vec,
  output logic [$clog2(INPUT_VEC_LEN+1)-1:0]    out_cnt
);

  localparam int IDX_W = (INPUT_VEC_LEN > 1) ? $clog2(INPUT_VEC_LEN) : 1;
  localparam int CNT_W = $clog2(INPUT_VEC_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_VEC_LEN - 1);

  typedef logic [INPUT_VEC_LEN-1:0][WIDTH-1:0] vec_t;

  vec_t             fill_q;
  vec_t             fill_d;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] fill_cnt_q;
  logic             fill_full_q;

  logic             accept;
  logic             complete;
  logic             flush_hit;
  logic             have_vec;
  logic             xfer;
  logic [CNT_W-1:0] cnt_now;
  logic [CNT_W-1:0] xfer_cnt;

  assign in_ready = rst_n & ~fill_full_q;
  assign accept   = in_valid & in_ready;
  assign cnt_now  = CNT_W'(idx_q) + CNT_W'(accept);
  assign complete = accept & (idx_q == LAST_IDX);

`ifdef DPE_LOADER_FLUSH_EN
  // A flush that coincides with a natural completion adds nothing; an empty flush is ignored.
  assign flush_hit = flush & ~fill_full_q & ~complete & (cnt_now != '0);
`else
  assign flush_hit = 1'b0;
`endif

  assign have_vec = fill_full_q | complete | flush_hit;
  assign xfer     = have_vec & (~out_valid | out_ready);
  assign xfer_cnt = fill_full_q ? fill_cnt_q : cnt_now;

  // NOTE: combinational blocks assign every output a default first, so no latch can be inferred.
  always_comb begin
    fill_d = fill_q;
    if (accept) fill_d[idx_q] = in_data;
  end

  // NOTE: reset is synchronous and clears the fill buffer too, so a flushed partial vector
  // always reads zero in its unloaded slots; state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_q      <= '0;
      idx_q       <= '0;
      fill_cnt_q  <= '0;
      fill_full_q <= 1'b0;
      out_valid   <= 1'b0;
      out_vec     <= '0;
      out_cnt     <= '0;
    end else begin
      // Output register: a new vector overwrites a consumed one with no bubble.
      if (xfer) begin
        out_vec   <= fill_d;
        out_cnt   <= xfer_cnt;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Fill side: hold a finished vector in the buffer while the output is blocked.
      if (fill_full_q) begin
        if (xfer) begin
          fill_full_q <= 1'b0;
          fill_q      <= '0;
        end
      end else if (complete || flush_hit) begin
        idx_q <= '0;
        if (xfer) begin
          fill_q <= '0;
        end else begin
          fill_q      <= fill_d;
          fill_cnt_q  <= cnt_now;
          fill_full_q <= 1'b1;
        end
      end else if (accept) begin
        fill_q <= fill_d;
        idx_q  <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dpe_vec_loader.sv
// Self-checking bench for dpe_vec_loader: table-driven streams plus hand-written corner cases,
// with a scoreboard queue of expected vectors checked on every output handshake.
module tb_dpe_vec_loader;
  localparam int N  = 8;
  localparam int W  = 16;
  localparam int CW = $clog2(N + 1);

  typedef logic [N-1:0][W-1:0] vec_t;
  typedef struct { vec_t vec; logic [CW-1:0] cnt; } exp_t;
  typedef struct { int n; int start; int step; int gap; int exp_vecs; } row_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          out_valid;
  vec_t          out_vec;
  logic [CW-1:0] out_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t sb_e;
  vec_t m_vec = '0;
  int   m_cnt = 0;
  int   pops = 0;
  int   drops = 0;
  bit   watch_drops = 1'b0;
  logic last_ov = 1'b0;

  logic          prev_rst = 1'b0;
  logic          prev_ov = 1'b0;
  logic          prev_or = 1'b0;
  vec_t          prev_vec = '0;
  logic [CW-1:0] prev_cnt = '0;

  always #5 clk = ~clk;

  dpe_vec_loader #(.INPUT_VEC_LEN(N), .WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
`ifdef DPE_LOADER_FLUSH_EN
    .flush(flush),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_vec(out_vec),
    .out_cnt(out_cnt)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkvec(input int start, input int step, input int count);
    vec_t v = '0;
    for (int k = 0; k < count; k++) v[k] = W'(start + k * step);
    return v;
  endfunction

  // Monitor and reference model, sampled on the falling edge while everything is stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      m_cnt = 0;
      m_vec = '0;
    end else begin
      if (prev_rst && prev_ov && !prev_or) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_vec", out_vec, prev_vec);
        check("hold_cnt", out_cnt, prev_cnt);
      end
      if (watch_drops && !in_ready) drops++;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_vec: got %0h with nothing expected", out_vec);
        end else begin
          sb_e = sb_q.pop_front();
          check("sb_vec", out_vec, sb_e.vec);
          check("sb_cnt", out_cnt, sb_e.cnt);
          pops++;
        end
      end
      if (in_valid && in_ready) begin
        m_vec[m_cnt] = in_data;
        m_cnt++;
      end
      if (m_cnt == N || (flush && m_cnt > 0)) begin
        sb_e.vec = m_vec;
        sb_e.cnt = CW'(m_cnt);
        sb_q.push_back(sb_e);
        m_cnt = 0;
        m_vec = '0;
      end
    end
    prev_rst = rst_n;
    prev_ov  = out_valid;
    prev_or  = out_ready;
    prev_vec = out_vec;
    prev_cnt = out_cnt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input int gap);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: element %0h not accepted within 200 cycles", d);
    end
    last_ov  = out_valid;
    in_valid = 1'b0;
    in_data  = W'($urandom);
    repeat (gap) tick();
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb_q.size() != 0; t++) tick();
    tick();
    check("drain_empty", sb_q.size(), 0);
  endtask

  row_t rows[4];

  initial begin
    rows[0] = '{n: 8,  start: 1,      step: 1, gap: 0,  exp_vecs: 1};
    rows[1] = '{n: 16, start: 1,      step: 1, gap: 0,  exp_vecs: 2};
    rows[2] = '{n: 8,  start: 'hFFFF, step: 0, gap: 1,  exp_vecs: 1};
    rows[3] = '{n: 24, start: 100,    step: 3, gap: -1, exp_vecs: 3};

    // Reset state
    repeat (2) tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_out_vec", out_vec, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    tick();

    // Streams with out_ready held high
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      pops = 0;
      drops = 0;
      watch_drops = 1'b1;
      for (int i = 0; i < rows[r].n; i++)
        send(W'(rows[r].start + i * rows[r].step),
             (rows[r].gap < 0) ? int'($urandom_range(0, 3)) : rows[r].gap);
      check("row_latency", last_ov, 1'b1);
      check("row_last_vec", out_vec, mkvec(rows[r].start + (rows[r].n - N) * rows[r].step, rows[r].step, N));
      check("row_last_cnt", out_cnt, N);
      watch_drops = 1'b0;
      drain();
      check("row_pops", pops, rows[r].exp_vecs);
      check("row_ready_drops", drops, 0);
    end

    // Downstream blocked: first vector held, fill buffer fills, input stalls
    out_ready = 1'b0;
    pops = 0;
    for (int i = 1; i <= 16; i++) send(W'(i), 0);
    check("blk_in_ready", in_ready, 1'b0);
    check("blk_out_valid", out_valid, 1'b1);
    check("blk_vec1", out_vec, mkvec(1, 1, N));
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    repeat (3) tick();
    check("blk_in_ready_held", in_ready, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("blk_vec2", out_vec, mkvec(9, 1, N));
    check("blk_vec2_valid", out_valid, 1'b1);
    check("blk_in_ready_back", in_ready, 1'b1);
    drain();
    check("blk_pops", pops, 2);

    // Reset with a held vector and a half-filled buffer
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(W'(40 + i), 0);
    for (int i = 0; i < 5; i++) send(W'(50 + i), 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b0);
    tick();
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_vec", out_vec, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("mid_rst_release", in_ready, 1'b1);
    tick();
    for (int i = 20; i <= 27; i++) send(W'(i), 0);
    check("after_rst_latency", last_ov, 1'b1);
    check("after_rst_vec", out_vec, mkvec(20, 1, N));
    drain();

`ifdef DPE_LOADER_FLUSH_EN
    // Partial vector flush, empty flush, and flush with a same-cycle element
    send(5, 0);
    send(6, 0);
    send(7, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", out_valid, 1'b1);
    check("flush_vec", out_vec, mkvec(5, 1, 3));
    check("flush_cnt", out_cnt, 3);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_empty", out_valid, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'd9;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_accept_valid", out_valid, 1'b1);
    check("flush_accept_vec", out_vec, mkvec(9, 0, 1));
    check("flush_accept_cnt", out_cnt, 1);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
